// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths, length type and FSM state encoding for the
// instruction-memory boot loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WORD_STEP      = 4;
  localparam int unsigned LEN_W          = 16;

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE
  } state_e;

  // States in which the loader consumes stream bytes.
  function automatic logic takes_bytes(input state_e s);
    return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port.
//   master : stream producer / memory observer (host side)
//   slave  : the loader (consumes bytes, drives the memory write port)
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [WORD_W-1:0] mem_wd;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_a, mem_wd
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_a, mem_wd
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer: assembles bytes little-endian into a word.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart at lane 0 with an empty word
//   push, din  : shift one byte in (first byte ends up in bits [7:0])
//   word       : assembly register (drives the memory write data)
//   full_c     : the lane counter sits on the last lane, so the next push
//                completes the word
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  output logic [WORD_W-1:0] word,
  output logic              full_c
);

  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;

  // Right-shift assembly: after BYTES_PER_WORD pushes byte 0 is in the low lane.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      lane <= '0;
      word <= '0;
    end else if (push) begin
      lane <= lane + LANE_W'(1);
      word <= {din, word[WORD_W-1:BYTE_W]};
    end
  end

  assign full_c = (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader for the instruction memory. Accepts a
// length-prefixed byte stream (16-bit little-endian word count, then payload),
// packs it into words and writes consecutive word addresses from BASE_ADDR,
// holding the core in reset meanwhile.
//   clk, reset : clock, synchronous active-high reset
//   start      : pulse, begins a load from IDLE or DONE (ignored while busy)
//   bus        : slave side of imem_loader_if (byte stream + memory write port)
//   cpu_hold   : keeps the core in reset during a load
//   busy       : load in progress
//   done, err  : load finished / load failed (err valid while done)
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over the length and payload bytes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       SIZE      = 2048,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e TAIL_STATE = S_CHK;
`else
  localparam state_e TAIL_STATE = S_DONE;
`endif

  state_e            state, state_n;
  len_t              count, count_n;
  len_t              word_cnt, word_cnt_n, word_cnt_inc;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              in_ready, in_ready_n;
  logic              mem_we, mem_we_n;
  logic              busy_n, done_n, err_n;
  logic              accept, start_load;
  logic              pk_push, pk_full_c;
  logic [WORD_W-1:0] pk_word;

  assign accept     = bus.in_valid && in_ready;
  assign start_load = start && ((state == S_IDLE) || (state == S_DONE));
  assign pk_push    = accept && (state == S_DATA);

  imem_loader_byte_packer u_packer (
    .clk    (clk),
    .reset  (reset),
    .clr    (start_load),
    .push   (pk_push),
    .din    (bus.in_data),
    .word   (pk_word),
    .full_c (pk_full_c)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum, csum_n;

  // Running XOR over both length bytes and all payload bytes.
  always_comb begin
    csum_n = csum;
    if (start_load) begin
      csum_n = '0;
    end else if (accept && (state != S_CHK)) begin
      csum_n = csum ^ bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum <= '0;
    end else begin
      csum <= csum_n;
    end
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    count_n      = count;
    word_cnt_n   = word_cnt;
    addr_n       = addr;
    err_n        = err;
    word_cnt_inc = word_cnt + len_t'(1);

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n    = S_LEN0;
          err_n      = 1'b0;
          addr_n     = BASE_ADDR;
          word_cnt_n = '0;
        end
      end
      S_LEN0: begin
        if (accept) begin
          count_n = {count[LEN_W-1:BYTE_W], bus.in_data};
          state_n = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          count_n = {bus.in_data, count[BYTE_W-1:0]};
          if (count_n == '0) begin
            state_n = TAIL_STATE;
          end else if (32'(count_n) > SIZE) begin
            state_n = S_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (pk_push && pk_full_c) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_n     = addr + ADDR_W'(WORD_STEP);
        word_cnt_n = word_cnt_inc;
        state_n    = (word_cnt_inc == count) ? TAIL_STATE : S_DATA;
      end
      S_CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) begin
          err_n   = (bus.in_data != csum);
          state_n = S_DONE;
        end
`else
        state_n = S_DONE;
`endif
      end
      default: state_n = S_IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    in_ready_n = takes_bytes(state_n);
    mem_we_n   = (state_n == S_WRITE);
    busy_n     = (state_n != S_IDLE) && (state_n != S_DONE);
    done_n     = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      word_cnt <= '0;
      addr     <= BASE_ADDR;
      in_ready <= 1'b0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      word_cnt <= word_cnt_n;
      addr     <= addr_n;
      in_ready <= in_ready_n;
      mem_we   <= mem_we_n;
      busy     <= busy_n;
      cpu_hold <= busy_n;
      done     <= done_n;
      err      <= err_n;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = mem_we;
  assign bus.mem_a    = addr;
  assign bus.mem_wd   = pk_word;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed table, hand-written corner sequences and random
// loads against a word-list reference model for imem_loader.
module tb_imem_loader;

  localparam int unsigned SIZE = 2048;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam int CK_EXTRA = 1;
`else
  localparam int CK_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic reset, start;
  logic cpu_hold, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.SIZE(SIZE), .BASE_ADDR(BASE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int acc0, ld_cycles;

  logic [15:0] ld_count;
  logic [7:0]  pay[$];
  logic [31:0] exp_w[$];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_flip = 8'h00;
`endif

  typedef struct {
    logic [15:0] count;
    logic [31:0] w0;
    logic [31:0] w1;
    int          stall;
    bit          exp_err;
    int          exp_n;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction-memory model: captures on the edge that ends a write cycle.
  always @(posedge clk) begin
    if (bus.mem_we) begin
      wr_a.push_back(bus.mem_a);
      wr_d.push_back(bus.mem_wd);
      check("we_only_in_write", 32'({bus.in_ready, busy}), 32'h1);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int stall, output int acc_cyc);
    repeat (stall) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int w = 0; w < 40 && !bus.in_ready; w++) @(negedge clk);
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 40 cycles");
    end
    @(negedge clk);
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_load(input int stall, input int poke);
    logic [7:0] s[$];
    int t;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
`endif
    wr_a.delete();
    wr_d.delete();
    s.push_back(ld_count[7:0]);
    s.push_back(ld_count[15:8]);
    if (32'(ld_count) <= SIZE) begin
      foreach (pay[i]) s.push_back(pay[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 8'h00;
      foreach (s[i]) x = x ^ s[i];
      s.push_back(x ^ csum_flip);
`endif
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'h1);
    check("hold_after_start", 32'(cpu_hold), 32'h1);
    acc0 = cyc;
    for (int i = 0; i < s.size(); i++) begin
      if (i == poke) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_byte(s[i], stall, t);
      if (i == 0) acc0 = t;
    end
    for (int w = 0; w < 40 && !done; w++) @(negedge clk);
    ld_cycles = cyc - acc0;
  endtask

  task automatic check_load(input string nm, input bit e_err, input int stall, input int poke);
    int exp_cyc;
    check({nm, "_done"}, 32'(done), 32'h1);
    check({nm, "_err"}, 32'(err), 32'(e_err));
    check({nm, "_busy"}, 32'({busy, cpu_hold}), 32'h0);
    check({nm, "_nwrites"}, 32'(wr_a.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_a.size(); i++) begin
      check($sformatf("%s_addr%0d", nm, i), wr_a[i], BASE + 32'(4 * i));
      check($sformatf("%s_data%0d", nm, i), wr_d[i], exp_w[i]);
    end
    if (stall == 0 && poke < 0) begin
      // Edges from the first accepted byte to done rising.
      exp_cyc = (32'(ld_count) > SIZE) ? 1 : 1 + 5 * int'(ld_count) + CK_EXTRA;
      check({nm, "_cycles"}, 32'(ld_cycles), 32'(exp_cyc));
    end
  endtask

  // Reference model: word list and error flag from the load description.
  task automatic model_load(output bit e);
    logic [31:0] w;
    exp_w.delete();
    e = (32'(ld_count) > SIZE);
    if (!e) begin
      for (int i = 0; i < int'(ld_count); i++) begin
        w = 32'h0;
        for (int k = 0; k < 4; k++) w = w + (32'(pay[4 * i + k]) << (8 * k));
        exp_w.push_back(w);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      e = (csum_flip != 8'h00);
`endif
    end
  endtask

  task automatic load_row(input int r);
    logic [31:0] w;
    ld_count = tbl[r].count;
    pay.delete();
    exp_w.delete();
    for (int k = 0; k < tbl[r].exp_n; k++) begin
      w = (k == 0) ? tbl[r].w0 : tbl[r].w1;
      exp_w.push_back(w);
      for (int b = 0; b < 4; b++) pay.push_back(w[8 * b +: 8]);
    end
  endtask

  initial begin
    bit e;
    int nw;

    tbl[0] = '{16'd2,      32'h0000_0513, 32'h0010_0093, 0, 1'b0, 2};
    tbl[1] = '{16'd2,      32'h0000_0513, 32'h0010_0093, 3, 1'b0, 2};
    tbl[2] = '{16'h0801,   32'h0,         32'h0,         0, 1'b1, 0};
    tbl[3] = '{16'd0,      32'h0,         32'h0,         0, 1'b0, 0};
    tbl[4] = '{16'd1,      32'hDEAD_BEEF, 32'h0,         1, 1'b0, 1};

    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'h0);
    check("rst_mem_a", bus.mem_a, BASE);
    check("rst_mem_wd", bus.mem_wd, 32'h0);
    check("rst_flags", 32'({cpu_hold, busy, done, err}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int r = 0; r < 5; r++) begin
      load_row(r);
      run_load(tbl[r].stall, -1);
      check_load($sformatf("vec%0d", r), tbl[r].exp_err, tbl[r].stall, -1);
    end

    // Reset after two payload bytes: partial word discarded, nothing written.
    load_row(4);
    wr_a.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h01, 0, nw);
    send_byte(8'h00, 0, nw);
    send_byte(8'h11, 0, nw);
    send_byte(8'h22, 0, nw);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'h0);
    check("midrst_mem_we", 32'(bus.mem_we), 32'h0);
    check("midrst_mem_a", bus.mem_a, BASE);
    check("midrst_mem_wd", bus.mem_wd, 32'h0);
    check("midrst_flags", 32'({cpu_hold, busy, done, err}), 32'h0);
    reset = 1'b0;
    check("midrst_nwrites", 32'(wr_a.size()), 32'h0);
    load_row(0);
    run_load(0, -1);
    check_load("after_rst", 1'b0, 0, -1);

    // Start pulsed during DATA is ignored.
    load_row(0);
    run_load(0, 4);
    check_load("start_in_data", 1'b0, 0, 4);

`ifdef IMEM_LOADER_CHECKSUM_EN
    ld_count = 16'd1;
    pay.delete();
    pay.push_back(8'hAA); pay.push_back(8'hBB); pay.push_back(8'hCC); pay.push_back(8'hDD);
    exp_w.delete();
    exp_w.push_back(32'hDDCC_BBAA);
    csum_flip = 8'h00;
    run_load(0, -1);
    check_load("csum_ok", 1'b0, 0, -1);
    csum_flip = 8'h01;
    run_load(0, -1);
    check_load("csum_bad", 1'b1, 0, -1);
    csum_flip = 8'h00;
`endif

    // Random loads against the reference model; the last one is oversize.
    for (int it = 0; it < 8; it++) begin
      pay.delete();
      if (it == 7) begin
        ld_count = 16'(SIZE + 1 + $urandom_range(0, 500));
      end else begin
        ld_count = 16'($urandom_range(1, 6));
        for (int b = 0; b < 4 * int'(ld_count); b++) pay.push_back(8'($urandom));
      end
      model_load(e);
      nw = $urandom_range(0, 2);
      run_load(nw, -1);
      check_load($sformatf("rand%0d", it), e, nw, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: time %0t reached without finishing", $time);
    $fatal(1);
  end

endmodule
